// File: rtl/mux_n_x_1_rr.sv
// Registered N-channel, W-bit multiplexer with per-channel valid/ready, explicit-select or round-robin mode.
// Optional saturating backpressure counter on stall_cnt when MUX_N_X_1_STALL_CNT_EN is defined.
module mux_n_x_1_rr #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SEL_W = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic [N*W-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_chan
`ifdef MUX_N_X_1_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic             vld_p0;
  logic [W-1:0]     data_p0;
  logic [SEL_W-1:0] chan_p0;
  logic [SEL_W-1:0] rr_ptr;

  logic [N-1:0]     sel_grant;
  logic [N-1:0]     rr_grant;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] gidx;
  logic [W-1:0]     gdata;
  logic             space;
  logic             xfer;

  // An out-of-range sel shifts the single bit off the top, so it grants nothing.
  assign sel_grant = in_valid & (N'(1) << sel);

  always_comb begin
    logic [N-1:0] tmp;
    rr_grant = '0;
    tmp      = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      tmp = in_valid >> idx;
      if (rr_grant == '0 && tmp[0]) rr_grant = N'(1) << idx;
    end
  end

  assign grant = mode ? rr_grant : sel_grant;
  assign space = !vld_p0 || out_ready;
  assign in_ready = grant & {N{space & rst_n}};
  assign xfer = |(in_valid & in_ready);

  always_comb begin
    logic [N-1:0]   gtmp;
    logic [N*W-1:0] dtmp;
    gidx = '0;
    gtmp = '0;
    for (int i = 0; i < N; i++) begin
      gtmp = grant >> i;
      if (gtmp[0]) gidx = SEL_W'(i);
    end
    dtmp  = in_data >> (W * int'(gidx));
    gdata = dtmp[W-1:0];
  end

  // Stage p0: single-entry output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      chan_p0 <= '0;
      rr_ptr  <= '0;
    end else begin
      if (xfer) begin
        vld_p0  <= 1'b1;
        data_p0 <= gdata;
        chan_p0 <= gidx;
        if (mode) rr_ptr <= (gidx == SEL_W'(N - 1)) ? '0 : gidx + SEL_W'(1);
      end else if (out_ready) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_chan  = chan_p0;

`ifdef MUX_N_X_1_STALL_CNT_EN
  logic [15:0] stall_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) stall_p0 <= '0;
    else if (vld_p0 && !out_ready) stall_p0 <= sat_inc16(stall_p0);
  end

  assign stall_cnt = stall_p0;
`endif

endmodule
